// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter. Bit timing comes from the rising edges of
// bclk, which is sampled in the clk domain. The host side uses a valid/ready handshake.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,     // async, active low
  input  logic                 bclk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam bit         ODD_PAR   = (PARITY == 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic                 bclk_q;
  logic                 tick;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 scnt_q, scnt_d;
  logic                 tx_d, rdy_d, busy_d;
  logic                 accept;

  // A bit boundary is the first clk cycle on which bclk is seen high.
  assign tick   = bclk & ~bclk_q;
  assign accept = tx_valid & tx_ready;

  // State, datapath and registered outputs. Reset takes effect immediately from any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bclk_q   <= 1'b0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      bcnt_q   <= '0;
      scnt_q   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bclk_q   <= bclk;
      sh_q     <= sh_d;
      par_q    <= par_d;
      bcnt_q   <= bcnt_d;
      scnt_q   <= scnt_d;
      tx       <= tx_d;
      tx_ready <= rdy_d;
      busy     <= busy_d;
    end
  end

  // Next-state logic. Only SYNC and later states advance on ticks, so a tick
  // that lands on the accept edge is not consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SYNC;
      SYNC:  if (tick) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bcnt_q == LAST_BIT) state_d = HAS_PAR ? PAR : STOP;
      PAR:   if (tick) state_d = STOP;
      STOP:  if (tick && scnt_q == LAST_STOP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. tx holds its value between ticks.
  // ready and busy follow the next state, so both change on the same edge as the state.
  always_comb begin
    tx_d   = tx;
    sh_d   = sh_q;
    par_d  = par_q;
    bcnt_d = bcnt_q;
    scnt_d = scnt_q;
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          sh_d  = tx_data;
          par_d = ODD_PAR ? ~^tx_data : ^tx_data;
        end
      end
      SYNC: if (tick) tx_d = 1'b0;
      START: if (tick) begin
        tx_d   = sh_q[0];
        sh_d   = sh_q >> 1;
        bcnt_d = '0;
      end
      DATA: if (tick) begin
        if (bcnt_q == LAST_BIT) begin
          tx_d   = HAS_PAR ? par_q : 1'b1;
          scnt_d = 1'b0;
        end else begin
          tx_d   = sh_q[0];
          sh_d   = sh_q >> 1;
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      PAR: if (tick) begin
        tx_d   = 1'b1;
        scnt_d = 1'b0;
      end
      STOP: if (tick) begin
        tx_d = 1'b1;
        if (scnt_q != LAST_STOP) scnt_d = scnt_q + 1'b1;
      end
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx. Three configurations share one stimulus stream: 8N1, 8E1 and 8O2.
// Each expected line waveform is built as a list of bit slots, one slot per bclk period.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bclk;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [2:0] txw, rdyw, bsyw;
  logic [3:0] bdiv = 4'd0;

  int n_pass = 0;
  int n_chk  = 0;

  int   par_cfg[3]  = '{0, 2, 1};
  int   stop_cfg[3] = '{1, 1, 2};
  logic exp_tx[3][64];
  logic exp_fr[3][64];

  always #5 clk = ~clk;

  // bclk is clk divided by 16, with 8 cycles high and 8 cycles low.
  always @(posedge clk) bdiv <= bdiv + 4'd1;
  assign bclk = bdiv[3];

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyw[0]), .tx(txw[0]), .busy(bsyw[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyw[1]), .tx(txw[1]), .busy(bsyw[1]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .bclk(bclk), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyw[2]), .tx(txw[2]), .busy(bsyw[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] etx, input logic [2:0] ebsy,
                         input logic [2:0] erdy);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s u%0d tx", tag, i), txw[i], etx[i]);
      chk($sformatf("%s u%0d busy", tag, i), bsyw[i], ebsy[i]);
      chk($sformatf("%s u%0d ready", tag, i), rdyw[i], erdy[i]);
    end
  endtask

  // Expected line per instance. Each frame is start, LSB-first data, optional parity,
  // then stop bits. Consecutive words are separated by one idle-high slot.
  task automatic model(input logic [7:0] w0, input logic [7:0] w1, input int nw);
    int pos;
    int ones;
    logic [7:0] w;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 64; k++) begin
        exp_tx[i][k] = 1'b1;
        exp_fr[i][k] = 1'b0;
      end
      pos = 0;
      for (int j = 0; j < nw; j++) begin
        w = (j == 0) ? w0 : w1;
        if (j > 0) pos++;
        exp_tx[i][pos] = 1'b0; exp_fr[i][pos] = 1'b1; pos++;
        for (int b = 0; b < 8; b++) begin
          exp_tx[i][pos] = w[b]; exp_fr[i][pos] = 1'b1; pos++;
        end
        if (par_cfg[i] != 0) begin
          ones = $countones(w);
          exp_tx[i][pos] = (par_cfg[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
          exp_fr[i][pos] = 1'b1; pos++;
        end
        for (int s = 0; s < stop_cfg[i]; s++) begin
          exp_tx[i][pos] = 1'b1; exp_fr[i][pos] = 1'b1; pos++;
        end
      end
    end
  endtask

  // Offer one word. With align set, the accept edge is also a tick edge.
  // The task returns just after the T0 edge, which is the first tick after the accept.
  task automatic send(input logic [7:0] d, input bit hold, input bit align, input logic [7:0] nd);
    @(negedge clk);
    if (align) begin
      for (int c = 0; c < 40; c++) begin
        if (bdiv == 4'd8) break;
        @(negedge clk);
      end
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 chk_all("accept", 3'b111, 3'b111, 3'b000);
    @(negedge clk);
    if (hold) tx_data = nd;
    else      tx_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bdiv == 4'd8) break;
      @(negedge clk);
    end
    chk_all("sync", 3'b111, 3'b111, 3'b000);
    @(posedge clk);
  endtask

  // Check each slot just after its opening edge and on the last negedge before the next tick.
  // When busy in slot k is followed by a frame in slot k+1, the next word was already accepted.
  task automatic run_slots(input int n, input int drop_slot, input int pulse_slot);
    logic e;
    for (int k = 0; k < n; k++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("s%0d u%0d tx_head", k, i), txw[i], exp_tx[i][k]);
        chk($sformatf("s%0d u%0d busy_head", k, i), bsyw[i], exp_fr[i][k]);
        chk($sformatf("s%0d u%0d ready_head", k, i), rdyw[i], ~exp_fr[i][k]);
      end
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (k == drop_slot && c == 2) tx_valid = 1'b0;
        if (k == pulse_slot && c == 2) begin tx_data = 8'h00; tx_valid = 1'b1; end
        if (k == pulse_slot && c == 3) tx_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        e = exp_fr[i][k] | exp_fr[i][k+1];
        chk($sformatf("s%0d u%0d tx_tail", k, i), txw[i], exp_tx[i][k]);
        chk($sformatf("s%0d u%0d busy_tail", k, i), bsyw[i], e);
        chk($sformatf("s%0d u%0d ready_tail", k, i), rdyw[i], ~e);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;

    // Reset state, and tx_ready rising one clk after release.
    #23 chk_all("in_reset", 3'b111, 3'b000, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_all("released", 3'b111, 3'b000, 3'b000);
    @(posedge clk);
    #1 chk_all("ready_up", 3'b111, 3'b000, 3'b111);

    // Basic frame 0xA5.
    model(8'hA5, 8'h00, 1); send(8'hA5, 1'b0, 1'b0, 8'h00); run_slots(13, -1, -1);
    // Parity: 0x07 gives an even-parity bit of 1 and an odd-parity bit of 0.
    model(8'h07, 8'h00, 1); send(8'h07, 1'b0, 1'b0, 8'h00); run_slots(13, -1, -1);
    // 0xFF, including the two-stop-bit instance.
    model(8'hFF, 8'h00, 1); send(8'hFF, 1'b0, 1'b0, 8'h00); run_slots(13, -1, -1);
    // Back-to-back words with valid held high until every instance has taken the second word.
    model(8'h55, 8'hAA, 2); send(8'h55, 1'b1, 1'b0, 8'hAA); run_slots(26, 12, -1);
    // Data change and a valid pulse mid-frame, both ignored.
    model(8'hC3, 8'h00, 1); send(8'hC3, 1'b0, 1'b0, 8'h00); run_slots(13, -1, 3);
    // Accept on a tick edge. That tick must not start the frame.
    d = 8'($urandom);
    model(d, 8'h00, 1); send(d, 1'b0, 1'b1, 8'h00); run_slots(13, -1, -1);
    // Random words at random phases relative to bclk.
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      model(d, 8'h00, 1); send(d, 1'b0, 1'b0, 8'h00); run_slots(13, -1, -1);
    end

    // Reset asserted mid-frame during data bit 3, which is slot 4.
    d = 8'h96;
    model(d, 8'h00, 1); send(d, 1'b0, 1'b0, 8'h00);
    repeat (4 * 16 + 8) @(posedge clk);
    #3;
    for (int i = 0; i < 3; i++) chk($sformatf("pre_rst u%0d tx", i), txw[i], exp_tx[i][4]);
    reset = 1'b0;
    #1 chk_all("rst_async", 3'b111, 3'b000, 3'b000);
    repeat (3) @(negedge clk);
    chk_all("rst_hold", 3'b111, 3'b000, 3'b000);
    reset = 1'b1;
    #1 chk_all("rst_release", 3'b111, 3'b000, 3'b000);
    @(posedge clk);
    #1 chk_all("rst_ready", 3'b111, 3'b000, 3'b111);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk_all($sformatf("post_rst c%0d", c), 3'b111, 3'b000, 3'b111);
    end
    // A clean frame after the reset.
    d = 8'($urandom);
    model(d, 8'h00, 1); send(d, 1'b0, 1'b0, 8'h00); run_slots(13, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
